// File: rtl/palette_lookup_arbiter_pkg.sv
// Shared sprite palette types and constants.
// Used by the palette lookup arbiter and its interface.
package sprite_pkg;

    localparam int NUM_REQ_DEF = 2;
    localparam int IDX_W       = 4;
    localparam int COLOR_W     = 4;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_DEF);

    localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    function automatic logic is_transp(logic [IDX_W-1:0] idx);
        return idx == TRANSP_IDX;
    endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Request, palette ROM and result signals of the palette lookup arbiter.
// The slave modport is the arbiter; master is the surrounding sprite logic.
interface palette_lookup_arbiter_if
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = sprite_pkg::NUM_REQ_DEF
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;

    logic [IDX_W-1:0]         pal_index;
    logic [COLOR_W-1:0]       pal_red;
    logic [COLOR_W-1:0]       pal_green;
    logic [COLOR_W-1:0]       pal_blue;

    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_id;
    logic [COLOR_W-1:0]       out_red;
    logic [COLOR_W-1:0]       out_green;
    logic [COLOR_W-1:0]       out_blue;
    logic                     out_transparent;

    modport master (
        output req_valid,
        output req_index,
        input  req_ready,
        input  pal_index,
        output pal_red,
        output pal_green,
        output pal_blue,
        input  out_valid,
        output out_ready,
        input  out_id,
        input  out_red,
        input  out_green,
        input  out_blue,
        input  out_transparent
    );

    modport slave (
        input  req_valid,
        input  req_index,
        output req_ready,
        output pal_index,
        input  pal_red,
        input  pal_green,
        input  pal_blue,
        output out_valid,
        input  out_ready,
        output out_id,
        output out_red,
        output out_green,
        output out_blue,
        output out_transparent
    );

endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin pick among valid requesters; the pointer remembers the
// last winner so the search starts just after it.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;

    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_valid && req_valid[ID_W'(cand)]) begin
                grant_valid           = 1'b1;
                grant[ID_W'(cand)]    = 1'b1;
                grant_id              = ID_W'(cand);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant_id;
        end
    end

    // Start pointing at the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational palette ROM between several sprite pipelines:
// round-robin grant, registered ROM index, registered tagged colour result.
module palette_lookup_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    palette_lookup_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;

    logic               s2_free;
    logic               s1_adv;
    logic               s1_can_load;
    logic               xfer;
    logic [IDX_W-1:0]   win_index;

    logic               s1_valid_q;
    logic               s1_valid_d;
    logic [IDX_W-1:0]   s1_index_q;
    logic [IDX_W-1:0]   s1_index_d;
    logic [ID_W-1:0]    s1_id_q;
    logic [ID_W-1:0]    s1_id_d;

    logic               out_valid_q;
    logic               out_valid_d;
    logic [ID_W-1:0]    out_id_q;
    logic [ID_W-1:0]    out_id_d;
    rgb_t               out_rgb_q;
    rgb_t               out_rgb_d;
    logic               out_transp_q;
    logic               out_transp_d;

    assign s2_free     = !out_valid_q || bus.out_ready;
    assign s1_adv      = s1_valid_q && s2_free;
    assign s1_can_load = !s1_valid_q || s1_adv;

    // Reset gates the grant so nothing is accepted while held in reset.
    assign xfer          = grant_valid && s1_can_load && Reset_n;
    assign bus.req_ready = (s1_can_load && Reset_n) ? grant : '0;
    assign win_index     = bus.req_index[int'(grant_id)*IDX_W +: IDX_W];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .req_valid   (bus.req_valid),
        .advance     (xfer),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_index_d = s1_index_q;
        s1_id_d    = s1_id_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_index_d = win_index;
            s1_id_d    = grant_id;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_rgb_d    = out_rgb_q;
        out_transp_d = out_transp_q;
        if (s1_adv) begin
            out_valid_d     = 1'b1;
            out_id_d        = s1_id_q;
            out_rgb_d.red   = bus.pal_red;
            out_rgb_d.green = bus.pal_green;
            out_rgb_d.blue  = bus.pal_blue;
            out_transp_d    = is_transp(s1_index_q);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_index_q <= s1_index_d;
            s1_id_q    <= s1_id_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_rgb_q    <= '0;
            out_transp_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_rgb_q    <= out_rgb_d;
            out_transp_q <= out_transp_d;
        end
    end

    assign bus.pal_index       = s1_index_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_id          = out_id_q;
    assign bus.out_red         = out_rgb_q.red;
    assign bus.out_green       = out_rgb_q.green;
    assign bus.out_blue        = out_rgb_q.blue;
    assign bus.out_transparent = out_transp_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Scoreboard bench for palette_lookup_arbiter with a stub palette ROM
// (red=index, green=~index, blue=index^5).
module tb_palette_lookup_arbiter;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    palette_lookup_arbiter_if #(.NUM_REQ(2)) bus();

    palette_lookup_arbiter #(.NUM_REQ(2)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always_comb begin
        bus.pal_red   = bus.pal_index;
        bus.pal_green = ~bus.pal_index;
        bus.pal_blue  = bus.pal_index ^ 4'h5;
    end

    typedef struct {
        req_id_t    id;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid result must match the oldest expected entry.
    initial begin
        exp_t       e;
        logic [3:0] g;
        logic [3:0] b;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got result id %0d red %0h, expected none",
                             bus.out_id, bus.out_red);
                end else begin
                    e = sb[0];
                    g = ~e.idx;
                    b = e.idx ^ 4'h5;
                    chk("out_id", 32'(bus.out_id), 32'(e.id));
                    chk("out_red", 32'(bus.out_red), 32'(e.idx));
                    chk("out_green", 32'(bus.out_green), 32'(g));
                    chk("out_blue", 32'(bus.out_blue), 32'(b));
                    chk("out_transp", 32'(bus.out_transparent),
                        32'(e.idx == 4'h0));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic step(string nm, logic [1:0] rv, logic [3:0] i0,
                        logic [3:0] i1, logic ordy, logic [1:0] er,
                        logic eov);
        exp_t e;
        @(negedge clk);
        bus.req_valid = rv;
        bus.req_index = {i1, i0};
        bus.out_ready = ordy;
        #1;
        chk({nm, "_rdy"}, 32'(bus.req_ready), 32'(er));
        chk({nm, "_ov"}, 32'(bus.out_valid), 32'(eov));
        if ((rv & er) != 2'b00) begin
            e.id  = er[1] ? 1'b1 : 1'b0;
            e.idx = er[1] ? i1 : i0;
            sb.push_back(e);
        end
    endtask

    initial begin
        int         idx;
        int         cyc;
        int         base;
        logic       tg;
        exp_t       e;

        bus.req_valid = '0;
        bus.req_index = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_index = 8'h93;
        #1;
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_rdy", 32'(bus.req_ready), 32'd0);
        chk("rst_pal", 32'(bus.pal_index), 32'd0);
        chk("rst_id", 32'(bus.out_id), 32'd0);
        chk("rst_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'd0);
        chk("rst_tr", 32'(bus.out_transparent), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;

        // single requester, latency
        step("t2c0", 2'b01, 4'h7, 4'h0, 1'b1, 2'b01, 1'b0);
        step("t2c1", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);
        step("t2c2", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1);
        step("t2c3", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);

        // transparent index from requester 1
        step("t4c0", 2'b10, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0);
        step("t4c1", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);
        step("t4c2", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1);
        step("t4c3", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);

        // both valid, alternating grants, no bubbles
        step("t3c0", 2'b11, 4'h3, 4'h9, 1'b1, 2'b01, 1'b0);
        step("t3c1", 2'b11, 4'h3, 4'h9, 1'b1, 2'b10, 1'b0);
        step("t3c2", 2'b11, 4'h3, 4'h9, 1'b1, 2'b01, 1'b1);
        step("t3c3", 2'b11, 4'h3, 4'h9, 1'b1, 2'b10, 1'b1);
        step("t3c4", 2'b00, 4'h3, 4'h9, 1'b1, 2'b00, 1'b1);
        step("t3c5", 2'b00, 4'h3, 4'h9, 1'b1, 2'b00, 1'b1);
        step("t3c6", 2'b00, 4'h3, 4'h9, 1'b1, 2'b00, 1'b0);

        // backpressure for 5 cycles
        step("t5c0", 2'b11, 4'hA, 4'h5, 1'b0, 2'b01, 1'b0);
        step("t5c1", 2'b11, 4'hA, 4'h5, 1'b0, 2'b10, 1'b0);
        step("t5c2", 2'b11, 4'hA, 4'h5, 1'b0, 2'b00, 1'b1);
        step("t5c3", 2'b11, 4'hA, 4'h5, 1'b0, 2'b00, 1'b1);
        step("t5c4", 2'b11, 4'hA, 4'h5, 1'b0, 2'b00, 1'b1);
        step("t5c5", 2'b11, 4'hA, 4'h5, 1'b1, 2'b01, 1'b1);
        step("t5c6", 2'b00, 4'hA, 4'h5, 1'b1, 2'b00, 1'b1);
        step("t5c7", 2'b00, 4'hA, 4'h5, 1'b1, 2'b00, 1'b1);
        step("t5c8", 2'b00, 4'hA, 4'h5, 1'b1, 2'b00, 1'b0);

        // streaming 0..15 with toggling out_ready
        idx  = 0;
        cyc  = 0;
        base = n_pop;
        tg   = 1'b1;
        while (idx < 16 && cyc < 200) begin
            @(negedge clk);
            bus.req_valid = 2'b01;
            bus.req_index = {4'h0, 4'(idx)};
            bus.out_ready = tg;
            tg = ~tg;
            cyc++;
            #1;
            if (bus.req_ready[0]) begin
                e.id  = 1'b0;
                e.idx = 4'(idx);
                sb.push_back(e);
                idx++;
            end
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            bus.out_ready = tg;
            tg = ~tg;
            cyc++;
        end
        chk("t6_sent", 32'(idx), 32'd16);
        chk("t6_delivered", 32'(n_pop - base), 32'd16);
        chk("t6_drained", 32'(sb.size()), 32'd0);
        step("t6_idle", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);

        // reset with two lookups in flight
        step("t1c0", 2'b01, 4'h4, 4'h0, 1'b0, 2'b01, 1'b0);
        step("t1c1", 2'b01, 4'h4, 4'h0, 1'b0, 2'b01, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        sb.delete();
        #1;
        chk("t1_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("t1_rst_rdy", 32'(bus.req_ready), 32'd0);
        chk("t1_rst_pal", 32'(bus.pal_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        step("t1c2", 2'b10, 4'h0, 4'h6, 1'b1, 2'b10, 1'b0);
        step("t1c3", 2'b00, 4'h0, 4'h6, 1'b1, 2'b00, 1'b0);
        step("t1c4", 2'b00, 4'h0, 4'h6, 1'b1, 2'b00, 1'b1);
        step("t1c5", 2'b00, 4'h0, 4'h6, 1'b1, 2'b00, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
